// File: rtl/mac_operand_feeder.sv
// Initiator side of a go/done MAC interface: queues operand pairs, issues them one at a
// time, captures each result into a single valid/ready slot, and watchdogs every operation.
module mac_operand_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  a_in,
    input  logic [3:0]  b_in,
    output logic        full,
    output logic        mac_go,
    output logic [3:0]  mac_a,
    output logic [3:0]  mac_b,
    input  logic        mac_done,
    input  logic [11:0] mac_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_data,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

    state_t         state_q, state_d;
    logic [7:0]     mem_q [DEPTH];
    logic [7:0]     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, full_d;
    logic           mac_go_q, mac_go_d;
    logic [3:0]     mac_a_q, mac_a_d;
    logic [3:0]     mac_b_q, mac_b_d;
    logic           res_valid_q, res_valid_d;
    logic [11:0]    res_data_q, res_data_d;
    logic [WW-1:0]  wd_q, wd_d;
    logic           timeout_err_q, timeout_err_d;
    logic [7:0]     op_count_q, op_count_d;

    logic           push;
    logic           pop;
    logic [7:0]     head;
    logic [WW-1:0]  wd_inc;

    // Pop only against the registered slot state, so a freed slot allows a pop one edge later.
    always_comb begin
        push   = wr_en && !full_q;
        pop    = (state_q == IDLE) && (count_q != '0) && !res_valid_q;
        head   = mem_q[rd_ptr_q];
        wd_inc = wd_q + 1'b1;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {a_in, b_in};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == DEPTH_C);
    end

    always_comb begin
        state_d       = state_q;
        mac_go_d      = 1'b0;
        mac_a_d       = mac_a_q;
        mac_b_d       = mac_b_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
        op_count_d    = op_count_q;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    mac_a_d  = head[7:4];
                    mac_b_d  = head[3:0];
                    mac_go_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mac_done) begin
                    res_data_d  = mac_out;
                    res_valid_d = 1'b1;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = IDLE;
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == TIMEOUT_C) begin
                        timeout_err_d = 1'b1;
                        state_d       = ERR;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            mac_go_q      <= 1'b0;
            mac_a_q       <= '0;
            mac_b_q       <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            mac_go_q      <= mac_go_d;
            mac_a_q       <= mac_a_d;
            mac_b_q       <= mac_b_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
            op_count_q    <= op_count_d;
        end
    end

    assign full        = full_q;
    assign mac_go      = mac_go_q;
    assign mac_a       = mac_a_q;
    assign mac_b       = mac_b_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign timeout_err = timeout_err_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench for mac_operand_feeder: a product-computing MAC model answers each go,
// expected results are queued at stimulus time and a monitor checks every accepted result.
module tb_mac_operand_feeder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  a_in;
    logic [3:0]  b_in;
    logic        full;
    logic        mac_go;
    logic [3:0]  mac_a;
    logic [3:0]  mac_b;
    logic        mac_done = 1'b0;
    logic [11:0] mac_out = '0;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_data;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  op_count;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q [$];
    int          go_count = 0;
    logic        prev_go  = 1'b0;

    int   model_delay = 4;
    bit   model_never = 1'b0;
    int   inject_req  = 0;
    int   inject_seen = 0;
    bit   pending     = 1'b0;
    int   cnt         = 0;
    logic [3:0] ma = '0;
    logic [3:0] mb = '0;

    always #5 clk = ~clk;

    mac_operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .a_in        (a_in),
        .b_in        (b_in),
        .full        (full),
        .mac_go      (mac_go),
        .mac_a       (mac_a),
        .mac_b       (mac_b),
        .mac_done    (mac_done),
        .mac_out     (mac_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy),
        .timeout_err (timeout_err),
        .op_count    (op_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        wr_en = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // MAC model: product of the operands, done a fixed number of cycles after go; resets with rst.
    always @(negedge clk) begin
        mac_done = 1'b0;
        if (rst !== 1'b1) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    pending = 1'b0;
                    checkOutput("mac_a_held", {28'd0, mac_a}, {28'd0, ma});
                    checkOutput("mac_b_held", {28'd0, mac_b}, {28'd0, mb});
                    mac_done = 1'b1;
                    mac_out  = 12'(ma) * 12'(mb);
                end
            end
            if (mac_go === 1'b1 && !model_never) begin
                pending = 1'b1;
                cnt     = model_delay;
                ma      = mac_a;
                mb      = mac_b;
            end
        end
        if (inject_seen != inject_req) begin
            inject_seen = inject_req;
            mac_done    = 1'b1;
            mac_out     = 12'hABC;
        end
    end

    // Monitor: every accepted result must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mac_go === 1'b1) begin
                go_count++;
                checkOutput("go_single", {31'd0, prev_go}, 32'd0);
            end
            prev_go = (mac_go === 1'b1);
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_result actual=%0h expected=none", res_data);
                end else begin
                    checkOutput("result", {20'd0, res_data}, {20'd0, exp_q.pop_front()});
                end
            end
        end else begin
            prev_go = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int go_before;
        rst       = 1'b1;
        wr_en     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        res_ready = 1'b0;
        step(2);

        // Mid-cycle asynchronous reset
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_go", {31'd0, mac_go}, 32'd0);
        checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_err", {31'd0, timeout_err}, 32'd0);
        checkOutput("rst_count", {24'd0, op_count}, 32'd0);
        checkOutput("rst_mac_a", {28'd0, mac_a}, 32'd0);
        checkOutput("rst_data", {20'd0, res_data}, 32'd0);
        @(posedge clk);
        #1;
        step(1);
        rst = 1'b1;
        step(1);

        // Single operation
        go_before = go_count;
        exp_q.push_back(12'd15);
        applyStimulus(4'd3, 4'd5);
        @(negedge clk);
        checkOutput("go_not_early", {31'd0, mac_go}, 32'd0);
        @(negedge clk);
        checkOutput("go_latency", {31'd0, mac_go}, 32'd1);
        checkOutput("go_mac_a", {28'd0, mac_a}, 32'd3);
        checkOutput("go_mac_b", {28'd0, mac_b}, 32'd5);
        for (int i = 0; i < 20 && res_valid !== 1'b1; i++) @(negedge clk);
        checkOutput("t2_valid", {31'd0, res_valid}, 32'd1);
        checkOutput("t2_data", {20'd0, res_data}, 32'd15);
        checkOutput("t2_count", {24'd0, op_count}, 32'd1);
        checkOutput("t2_gos", go_count - go_before, 32'd1);
        @(posedge clk);
        #1;

        // Fill the FIFO behind a held result; the fifth push is dropped
        go_before = go_count;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(4'(i), 4'(i));
            exp_q.push_back(12'(i * i));
        end
        @(negedge clk);
        checkOutput("t3_full", {31'd0, full}, 32'd1);
        checkOutput("t3_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(4'd5, 4'd5);
        checkOutput("t3_no_go", go_count - go_before, 32'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t3_drained", exp_q.size(), 32'd0);
        checkOutput("t3_count", {24'd0, op_count}, 32'd5);
        checkOutput("t3_busy_idle", {31'd0, busy}, 32'd0);
        checkOutput("t3_full_clr", {31'd0, full}, 32'd0);
        @(posedge clk);
        #1;

        // Backpressure holds the slot and blocks further issue
        res_ready = 1'b0;
        exp_q.push_back(12'd6);
        exp_q.push_back(12'd42);
        applyStimulus(4'd2, 4'd3);
        applyStimulus(4'd6, 4'd7);
        for (int i = 0; i < 20 && res_valid !== 1'b1; i++) @(negedge clk);
        @(posedge clk);
        #1;
        go_before = go_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t4_hold_data", {20'd0, res_data}, 32'd6);
        end
        checkOutput("t4_hold_valid", {31'd0, res_valid}, 32'd1);
        checkOutput("t4_no_go", go_count - go_before, 32'd0);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        checkOutput("t4_go_wait", {31'd0, mac_go}, 32'd0);
        @(negedge clk);
        checkOutput("t4_go_after_accept", {31'd0, mac_go}, 32'd1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t4_drained", exp_q.size(), 32'd0);
        checkOutput("t4_count", {24'd0, op_count}, 32'd7);
        @(posedge clk);
        #1;

        // Watchdog: the MAC never answers
        model_never = 1'b1;
        applyStimulus(4'd1, 4'd2);
        for (int i = 0; i < 10 && mac_go !== 1'b1; i++) @(negedge clk);
        checkOutput("t5_go_seen", {31'd0, mac_go}, 32'd1);
        repeat (TIMEOUT) @(negedge clk);
        checkOutput("t5_err_early", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        checkOutput("t5_err", {31'd0, timeout_err}, 32'd1);
        checkOutput("t5_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        go_before = go_count;
        for (int i = 0; i < 4; i++) applyStimulus(4'(i + 8), 4'(i));
        step(5);
        @(negedge clk);
        checkOutput("t5_full", {31'd0, full}, 32'd1);
        checkOutput("t5_no_go", go_count - go_before, 32'd0);
        checkOutput("t5_err_sticky", {31'd0, timeout_err}, 32'd1);
        @(posedge clk);
        #1;

        // Reset while waiting on the MAC with two pairs queued
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        model_never = 1'b0;
        model_delay = 30;
        res_ready   = 1'b1;
        step(1);
        checkOutput("t6_err_clr", {31'd0, timeout_err}, 32'd0);
        applyStimulus(4'd1, 4'd3);
        applyStimulus(4'd2, 4'd4);
        applyStimulus(4'd3, 4'd5);
        step(3);
        checkOutput("t6_busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_full", {31'd0, full}, 32'd0);
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_count", {24'd0, op_count}, 32'd0);
        checkOutput("t6_err", {31'd0, timeout_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(2);
        inject_req++;
        step(10);
        checkOutput("t6_no_late_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("t6_count_after", {24'd0, op_count}, 32'd0);
        checkOutput("t6_idle", {31'd0, busy}, 32'd0);

        checkOutput("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
